mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 21 ++
 rtl/mem_wb_stage_load_ext.sv | 46 ++++
 rtl/mem_wb_stage.sv | 93 +++++++++
 tb/tb_mem_wb_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM/WB pipeline stage:
// result-select encoding and load funct3 codes.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSV  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int RD_W  = 5;
  localparam int CNT_W = 64;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational load lane select and sign/zero extend
// from an aligned memory word.
module load_ext
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // addr[0] is ignored for halfword loads
  assign half_sel = addr_i[1] ? word_i[31:16]
                              : word_i[15:0];

  always_comb begin
    value_o = word_i;
    case (funct3_i)
      F3_LB: value_o =
        {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU: value_o =
        {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH: value_o =
        {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LHU: value_o =
        {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: result select, load extend,
// register-file write port and retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic                  m_reg_write,
  input  logic [4:0]            m_rd,
  input  logic [1:0]            m_result_src,
  input  logic [2:0]            m_funct3,
  input  logic [DATA_WIDTH-1:0] m_alu_result,
  input  logic [DATA_WIDTH-1:0] m_read_data,
  input  logic [DATA_WIDTH-1:0] m_pc_plus4,
  input  logic                  stall,
  input  logic                  flush,
  output logic [4:0]            a3,
  output logic                  we3,
  output logic [DATA_WIDTH-1:0] wd3,
  output logic                  fwd_valid,
  output logic [63:0]           instret
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [RD_W-1:0]       rd;
    logic [DATA_WIDTH-1:0] wd;
  } wb_t;

  wb_t                   wb_d, wb_q;
  logic [CNT_W-1:0]      instret_d, instret_q;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] res_val;
  result_src_e           src;

  load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .funct3_i(m_funct3),
    .addr_i  (m_alu_result[1:0]),
    .word_i  (m_read_data),
    .value_o (load_val)
  );

  assign src = result_src_e'(m_result_src);

  always_comb begin
    res_val = m_alu_result;
    case (src)
      RES_LOAD: res_val = load_val;
      RES_PC4:  res_val = m_pc_plus4;
      default:  res_val = m_alu_result;
    endcase
  end

  // flush wins over stall so a killed slot never lingers
  always_comb begin
    wb_d      = wb_q;
    instret_d = instret_q;
    if (flush) begin
      wb_d = '0;
    end else if (!stall) begin
      wb_d.valid     = m_valid;
      wb_d.reg_write = m_reg_write;
      wb_d.rd        = m_rd;
      wb_d.wd        = res_val;
      if (m_valid)
        instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q      <= '0;
      instret_q <= '0;
    end else begin
      wb_q      <= wb_d;
      instret_q <= instret_d;
    end
  end

  assign a3  = wb_q.rd;
  assign wd3 = wb_q.wd;
  assign we3 = wb_q.valid & wb_q.reg_write
             & (wb_q.rd != 5'd0);
  assign fwd_valid = we3;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus
// stall, reset and counter-wrap sequences.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic        m_reg_write;
  logic [4:0]  m_rd;
  logic [1:0]  m_result_src;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result;
  logic [31:0] m_read_data;
  logic [31:0] m_pc_plus4;
  logic        stall;
  logic        flush;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic        fwd_valid;
  logic [63:0] instret;

  int total;
  int bad;
  logic [63:0] exp_cnt;

  mem_wb_stage #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .m_reg_write (m_reg_write),
    .m_rd        (m_rd),
    .m_result_src(m_result_src),
    .m_funct3    (m_funct3),
    .m_alu_result(m_alu_result),
    .m_read_data (m_read_data),
    .m_pc_plus4  (m_pc_plus4),
    .stall       (stall),
    .flush       (flush),
    .a3          (a3),
    .we3         (we3),
    .wd3         (wd3),
    .fwd_valid   (fwd_valid),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic        st;
    logic        fl;
    logic        e_we;
    logic        chk_data;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_inc;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw,
                       input logic [4:0] rd,
                       input logic [1:0] src,
                       input logic [2:0] f3,
                       input logic [31:0] alu,
                       input logic [31:0] rdat,
                       input logic [31:0] pc4,
                       input logic st, input logic fl);
    m_valid      = v;
    m_reg_write  = rw;
    m_rd         = rd;
    m_result_src = src;
    m_funct3     = f3;
    m_alu_result = alu;
    m_read_data  = rdat;
    m_pc_plus4   = pc4;
    stall        = st;
    flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string nm, logic v,
      logic rw, logic [4:0] rd, logic [1:0] src,
      logic [2:0] f3, logic [31:0] alu,
      logic [31:0] rdat, logic [31:0] pc4,
      logic st, logic fl, logic e_we, logic cd,
      logic [4:0] e_a3, logic [31:0] e_wd,
      logic e_inc);
    vec_t r;
    r.name = nm; r.v = v; r.rw = rw; r.rd = rd;
    r.src = src; r.f3 = f3; r.alu = alu;
    r.rdat = rdat; r.pc4 = pc4; r.st = st;
    r.fl = fl; r.e_we = e_we; r.chk_data = cd;
    r.e_a3 = e_a3; r.e_wd = e_wd; r.e_inc = e_inc;
    return r;
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 64'd0;

    vt[0]  = mk("lb_off3", 1,1,5,2'b01,3'b000,
      32'h1003,32'h80112233,0, 0,0, 1,1,5,32'hFFFFFF80,1);
    vt[1]  = mk("lbu_off3",1,1,5,2'b01,3'b100,
      32'h1003,32'h80112233,0, 0,0, 1,1,5,32'h00000080,1);
    vt[2]  = mk("lb_off0", 1,1,6,2'b01,3'b000,
      32'h1000,32'h80112233,0, 0,0, 1,1,6,32'h00000033,1);
    vt[3]  = mk("lb_off1", 1,1,6,2'b01,3'b000,
      32'h1001,32'h80112233,0, 0,0, 1,1,6,32'h00000022,1);
    vt[4]  = mk("lbu_off2",1,1,6,2'b01,3'b100,
      32'h1002,32'h80112233,0, 0,0, 1,1,6,32'h00000011,1);
    vt[5]  = mk("lh_hi",   1,1,8,2'b01,3'b001,
      32'h2002,32'h9ABC1234,0, 0,0, 1,1,8,32'hFFFF9ABC,1);
    vt[6]  = mk("lhu_hi",  1,1,8,2'b01,3'b101,
      32'h2002,32'h9ABC1234,0, 0,0, 1,1,8,32'h00009ABC,1);
    vt[7]  = mk("lh_a0ign",1,1,8,2'b01,3'b001,
      32'h2003,32'h9ABC1234,0, 0,0, 1,1,8,32'hFFFF9ABC,1);
    vt[8]  = mk("lhu_lo",  1,1,8,2'b01,3'b101,
      32'h2000,32'h9ABC1234,0, 0,0, 1,1,8,32'h00001234,1);
    vt[9]  = mk("lw",      1,1,9,2'b01,3'b010,
      32'h2002,32'h9ABC1234,0, 0,0, 1,1,9,32'h9ABC1234,1);
    vt[10] = mk("lw_f3_011",1,1,9,2'b01,3'b011,
      32'h2001,32'h9ABC1234,0, 0,0, 1,1,9,32'h9ABC1234,1);
    vt[11] = mk("alu_x0",  1,1,0,2'b00,3'b000,
      32'h55,32'hFFFFFFFF,0, 0,0, 0,1,0,32'h00000055,1);
    vt[12] = mk("src_rsv", 1,1,7,2'b11,3'b000,
      32'hDEADBEEF,32'h1,32'h2, 0,0,
      1,1,7,32'hDEADBEEF,1);
    vt[13] = mk("invalid", 0,1,3,2'b00,3'b000,
      32'h77,0,0, 0,0, 0,1,3,32'h00000077,0);
    vt[14] = mk("flush",   1,1,6,2'b00,3'b000,
      32'h66,0,0, 0,1, 0,0,0,0,0);
    vt[15] = mk("flush_stall",1,1,6,2'b00,3'b000,
      32'h99,0,0, 1,1, 0,0,0,0,0);

    rst = 1'b1;
    drive(1,1,5'd12,2'b00,3'b010,32'hABCD,0,0,1,1);
    tick();
    tick();
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_fwd", fwd_valid, 0);
    chk("rst_instret", instret, 0);
    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,0);
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].v, vt[i].rw, vt[i].rd, vt[i].src,
            vt[i].f3, vt[i].alu, vt[i].rdat,
            vt[i].pc4, vt[i].st, vt[i].fl);
      tick();
      if (vt[i].e_inc) exp_cnt = exp_cnt + 64'd1;
      chk({vt[i].name, "_we3"}, we3, vt[i].e_we);
      chk({vt[i].name, "_fwd"}, fwd_valid, vt[i].e_we);
      if (vt[i].chk_data) begin
        chk({vt[i].name, "_a3"}, a3, vt[i].e_a3);
        chk({vt[i].name, "_wd3"}, wd3, vt[i].e_wd);
      end
      chk({vt[i].name, "_cnt"}, instret, exp_cnt);
    end

    drive(1,1,5'd1,2'b10,3'b000,32'h44,0,
          32'h00000104,0,0);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("jal_wd3", wd3, 32'h00000104);
    chk("jal_we3", we3, 1);
    chk("jal_a3", a3, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1,1,5'd20,2'b00,3'b000,32'h3333,0,0,1,0);
      tick();
      chk("stall_wd3", wd3, 32'h00000104);
      chk("stall_a3", a3, 1);
      chk("stall_we3", we3, 1);
      chk("stall_cnt", instret, exp_cnt);
    end
    drive(0,0,0,0,0,0,0,0,0,0);
    tick();
    chk("unstall_we3", we3, 0);
    chk("unstall_cnt", instret, exp_cnt);

    drive(1,1,5'd9,2'b01,3'b010,32'h10,
          32'hCAFEF00D,0,0,0);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("held_ld_wd3", wd3, 32'hCAFEF00D);
    chk("held_ld_cnt", instret, exp_cnt);
    drive(1,1,5'd9,2'b01,3'b010,32'h10,
          32'hCAFEF00D,0,1,0);
    tick();
    chk("held_ld_we3", we3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 64'd0;
    chk("rst_stall_we3", we3, 0);
    chk("rst_stall_cnt", instret, 0);
    chk("rst_stall_wd3", wd3, 0);
    drive(0,0,0,0,0,0,0,0,0,0);
    tick();

    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    #1;
    chk("preload", instret, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(1,0,5'd2,2'b00,3'b000,32'h1,0,0,0,0);
    tick();
    chk("pre_wrap", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap", instret, 64'd0);
    drive(0,0,0,0,0,0,0,0,0,0);
    tick();
    chk("post_wrap", instret, 64'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
